// File: rtl/wb_writeback_stage_if.sv
// wb_writeback_stage_if
// Bundles the MEM-stage retire handshake and the data-memory read return
// consumed by the write-back stage.
//   master: MEM stage / data memory side (drives instruction + load data)
//   slave : write-back stage (drives in_ready)
interface wb_writeback_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_regwrite;
  logic        in_memtoreg;
  logic [4:0]  in_writereg;
  logic [31:0] in_aluresult;
  logic [2:0]  in_loadtype;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output in_valid, in_regwrite, in_memtoreg, in_writereg,
           in_aluresult, in_loadtype, mem_rvalid, mem_rdata,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_regwrite, in_memtoreg, in_writereg,
           in_aluresult, in_loadtype, mem_rvalid, mem_rdata,
    output in_ready
  );
endinterface

// File: rtl/wb_writeback_stage.sv
// wb_writeback_stage
// Write-back stage of the MIPS pipeline and sole driver of the register-file
// write port. Accepts retired instructions from MEM, waits for load data when
// needed, aligns/extends sub-word loads (big-endian), suppresses writes to $0
// and misaligned loads, and presents each write for exactly one cycle.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : MEM handshake + data-memory read return
//   RegWrite/writereg/writedata : register-file write port (registered)
//   fwd_valid/fwd_reg/fwd_data  : same-cycle bypass to ID (copies of above)
//   addr_err          : one-cycle pulse for a misaligned load
//   retired_count     : number of instructions retired (wraps)
module wb_writeback_stage (
  input  logic                        clk,
  input  logic                        reset,
  wb_writeback_stage_if.slave         bus,
  output logic                        RegWrite,
  output logic [4:0]                  writereg,
  output logic [31:0]                 writedata,
  output logic                        fwd_valid,
  output logic [4:0]                  fwd_reg,
  output logic [31:0]                 fwd_data,
  output logic                        addr_err,
  output logic [31:0]                 retired_count
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_WAIT_LOAD = 2'd2
  } state_t;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  // Bytes never misalign; halfwords need addr[0]=0; words (and the
  // undefined encodings, which act as LW) need addr[1:0]=0.
  function automatic logic load_misaligned(input logic [2:0] lt, input logic [1:0] a);
    logic m;
    case (lt)
      LT_LB, LT_LBU: m = 1'b0;
      LT_LH, LT_LHU: m = a[0];
      default:       m = (a != 2'b00);
    endcase
    return m;
  endfunction

  // Big-endian lane select: byte k sits at word[31-8k -: 8].
  function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] a,
                                             input logic [2:0] lt);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = a[1] ? word[15:0] : word[31:16];
    case (lt)
      LT_LB:   r = {{24{b[7]}}, b};
      LT_LBU:  r = {24'd0, b};
      LT_LH:   r = {{16{h[15]}}, h};
      LT_LHU:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  writereg_q, writereg_d;
  logic [31:0] writedata_q, writedata_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] retired_q, retired_d;
  logic        pend_rw_q, pend_rw_d;
  logic [4:0]  pend_reg_q, pend_reg_d;
  logic [1:0]  pend_addr_q, pend_addr_d;
  logic [2:0]  pend_lt_q, pend_lt_d;

  logic in_ready_s;
  logic accept_s;
  logic mis_s;

  assign in_ready_s   = (state_q != ST_WAIT_LOAD);
  assign bus.in_ready = in_ready_s;
  assign accept_s     = bus.in_valid & in_ready_s;
  assign mis_s        = load_misaligned(pend_lt_q, pend_addr_q);

  // Next-state, write-port and pending-load computation.
  always_comb begin
    state_d     = state_q;
    regwrite_d  = 1'b0;
    addr_err_d  = 1'b0;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    pend_rw_d   = pend_rw_q;
    pend_reg_d  = pend_reg_q;
    pend_addr_d = pend_addr_q;
    pend_lt_d   = pend_lt_q;

    // Every cycle spent in WRITE retires exactly one instruction.
    if (state_q == ST_WRITE) begin
      retired_d = retired_q + 32'd1;
    end else begin
      retired_d = retired_q;
    end

    case (state_q)
      ST_IDLE, ST_WRITE: begin
        if (accept_s) begin
          if (bus.in_memtoreg) begin
            pend_rw_d   = bus.in_regwrite;
            pend_reg_d  = bus.in_writereg;
            pend_addr_d = bus.in_aluresult[1:0];
            pend_lt_d   = bus.in_loadtype;
            state_d     = ST_WAIT_LOAD;
          end else begin
            regwrite_d  = bus.in_regwrite & (bus.in_writereg != 5'd0);
            writereg_d  = bus.in_writereg;
            writedata_d = bus.in_aluresult;
            state_d     = ST_WRITE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_LOAD: begin
        if (bus.mem_rvalid) begin
          regwrite_d  = pend_rw_q & (pend_reg_q != 5'd0) & ~mis_s;
          addr_err_d  = mis_s;
          writereg_d  = pend_reg_q;
          writedata_d = load_align(bus.mem_rdata, pend_addr_q, pend_lt_q);
          state_d     = ST_WRITE;
        end else begin
          state_d = ST_WAIT_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any pending load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      regwrite_q  <= 1'b0;
      writereg_q  <= 5'd0;
      writedata_q <= 32'd0;
      addr_err_q  <= 1'b0;
      retired_q   <= 32'd0;
      pend_rw_q   <= 1'b0;
      pend_reg_q  <= 5'd0;
      pend_addr_q <= 2'd0;
      pend_lt_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
      addr_err_q  <= addr_err_d;
      retired_q   <= retired_d;
      pend_rw_q   <= pend_rw_d;
      pend_reg_q  <= pend_reg_d;
      pend_addr_q <= pend_addr_d;
      pend_lt_q   <= pend_lt_d;
    end
  end

  assign RegWrite      = regwrite_q;
  assign writereg      = writereg_q;
  assign writedata     = writedata_q;
  assign addr_err      = addr_err_q;
  assign retired_count = retired_q;
  assign fwd_valid     = regwrite_q;
  assign fwd_reg       = writereg_q;
  assign fwd_data      = writedata_q;

endmodule

// File: tb/tb_wb_writeback_stage.sv
// tb_wb_writeback_stage
// Scoreboard bench: each issued instruction that should produce a visible
// write-port event (a write or an addr_err pulse) pushes its expected result;
// a negedge monitor pops and compares whenever the DUT shows such an event.
module tb_wb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic        addr_err;
  logic [31:0] retired_count;

  wb_writeback_stage_if bus();

  wb_writeback_stage dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .RegWrite      (RegWrite),
    .writereg      (writereg),
    .writedata     (writedata),
    .fwd_valid     (fwd_valid),
    .fwd_reg       (fwd_reg),
    .fwd_data      (fwd_data),
    .addr_err      (addr_err),
    .retired_count (retired_count)
  );

  typedef struct {
    logic        rw;
    logic [4:0]  rg;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_count = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: every visible write-port event must match the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (RegWrite === 1'b1 || addr_err === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_event", {30'd0, RegWrite, addr_err}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("regwrite", {31'd0, RegWrite}, {31'd0, e.rw});
        check_eq("fwd_valid", {31'd0, fwd_valid}, {31'd0, e.rw});
        check_eq("addr_err", {31'd0, addr_err}, {31'd0, e.err});
        if (e.rw) begin
          check_eq("writereg", {27'd0, writereg}, {27'd0, e.rg});
          check_eq("writedata", writedata, e.data);
          check_eq("fwd_reg", {27'd0, fwd_reg}, {27'd0, e.rg});
          check_eq("fwd_data", fwd_data, e.data);
        end
      end
    end
  end

  task automatic push_exp(input logic rw, input logic [4:0] rg, input logic [31:0] d,
                          input logic err);
    exp_t e;
    e.rw = rw; e.rg = rg; e.data = d; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic issue_alu(input logic [4:0] rg, input logic [31:0] d, input logic rw);
    bus.in_valid     = 1'b1;
    bus.in_memtoreg  = 1'b0;
    bus.in_regwrite  = rw;
    bus.in_writereg  = rg;
    bus.in_aluresult = d;
    bus.in_loadtype  = 3'd0;
    if (rw && rg != 5'd0) push_exp(1'b1, rg, d, 1'b0);
    model_count = model_count + 32'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic issue_load(input logic [4:0] rg, input logic [1:0] a, input logic [2:0] lt,
                            input logic [31:0] word, input int delay, input logic rw,
                            input logic [31:0] exp_data, input logic exp_err);
    bus.in_valid     = 1'b1;
    bus.in_memtoreg  = 1'b1;
    bus.in_regwrite  = rw;
    bus.in_writereg  = rg;
    bus.in_aluresult = {30'h04000010, a};
    bus.in_loadtype  = lt;
    if (exp_err) push_exp(1'b0, rg, 32'd0, 1'b1);
    else if (rw && rg != 5'd0) push_exp(1'b1, rg, exp_data, 1'b0);
    model_count = model_count + 32'd1;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.in_memtoreg = 1'b0;
    bus.mem_rdata   = ~word;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check_eq("ready_wait", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = word;
    @(negedge clk);
    check_eq("ready_rvalid", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    check_eq("ready_after_load", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic settle();
    repeat (2) begin
      @(posedge clk); #1;
    end
    check_eq("retired_count", retired_count, model_count);
    check_eq("sb_drained", sb_q.size(), 32'd0);
    check_eq("idle_regwrite", {31'd0, RegWrite}, 32'd0);
  endtask

  initial begin
    reset            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_regwrite  = 1'b0;
    bus.in_memtoreg  = 1'b0;
    bus.in_writereg  = 5'd0;
    bus.in_aluresult = 32'd0;
    bus.in_loadtype  = 3'd0;
    bus.mem_rvalid   = 1'b0;
    bus.mem_rdata    = 32'd0;

    // Reset values
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check_eq("rst_writereg", {27'd0, writereg}, 32'd0);
    check_eq("rst_writedata", writedata, 32'd0);
    check_eq("rst_addr_err", {31'd0, addr_err}, 32'd0);
    check_eq("rst_count", retired_count, 32'd0);
    check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single ALU write, presented for exactly one cycle
    issue_alu(5'd5, 32'h0000_1234, 1'b1);
    @(negedge clk);
    check_eq("alu_regwrite_now", {31'd0, RegWrite}, 32'd1);
    @(posedge clk); #1;
    check_eq("alu_regwrite_gone", {31'd0, RegWrite}, 32'd0);
    settle();

    // Back-to-back ALU writes
    bus.in_valid     = 1'b1;
    bus.in_memtoreg  = 1'b0;
    bus.in_regwrite  = 1'b1;
    bus.in_writereg  = 5'd3;
    bus.in_aluresult = 32'h0000_000A;
    push_exp(1'b1, 5'd3, 32'h0000_000A, 1'b0);
    model_count = model_count + 32'd1;
    @(posedge clk); #1;
    bus.in_writereg  = 5'd4;
    bus.in_aluresult = 32'h0000_000B;
    push_exp(1'b1, 5'd4, 32'h0000_000B, 1'b0);
    model_count = model_count + 32'd1;
    @(negedge clk);
    check_eq("b2b_ready", {31'd0, bus.in_ready}, 32'd1);
    check_eq("b2b_first_reg", {27'd0, writereg}, 32'd3);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_second_rw", {31'd0, RegWrite}, 32'd1);
    check_eq("b2b_second_reg", {27'd0, writereg}, 32'd4);
    settle();

    // Sub-word and word loads
    issue_load(5'd7, 2'd1, 3'd1, 32'h12F4_5678, 3, 1'b1, 32'hFFFF_FFF4, 1'b0); settle();
    issue_load(5'd8, 2'd1, 3'd2, 32'h12F4_5678, 3, 1'b1, 32'h0000_00F4, 1'b0); settle();
    issue_load(5'd9, 2'd2, 3'd3, 32'hAAAA_8001, 1, 1'b1, 32'hFFFF_8001, 1'b0); settle();
    issue_load(5'd10, 2'd0, 3'd4, 32'h8001_AAAA, 0, 1'b1, 32'h0000_8001, 1'b0); settle();
    issue_load(5'd11, 2'd3, 3'd1, 32'h1234_5680, 2, 1'b1, 32'hFFFF_FF80, 1'b0); settle();
    issue_load(5'd12, 2'd0, 3'd1, 32'h7F34_5680, 0, 1'b1, 32'h0000_007F, 1'b0); settle();
    issue_load(5'd13, 2'd0, 3'd0, 32'hDEAD_BEEF, 1, 1'b1, 32'hDEAD_BEEF, 1'b0); settle();
    issue_load(5'd14, 2'd0, 3'd6, 32'hCAFE_F00D, 0, 1'b1, 32'hCAFE_F00D, 1'b0); settle();
    // Misaligned loads: write suppressed, addr_err pulse, still retires
    issue_load(5'd15, 2'd2, 3'd0, 32'h1111_2222, 0, 1'b1, 32'd0, 1'b1); settle();
    issue_load(5'd16, 2'd1, 3'd4, 32'h1111_2222, 1, 1'b1, 32'd0, 1'b1); settle();
    // Writes to $0 and non-writing instructions: no event, count advances
    issue_alu(5'd0, 32'h5555_5555, 1'b1); settle();
    issue_load(5'd0, 2'd0, 3'd0, 32'h6666_6666, 1, 1'b1, 32'd0, 1'b0); settle();
    issue_alu(5'd6, 32'h7777_7777, 1'b0); settle();

    // ALU accepted in the same cycle a load result is presented
    issue_load(5'd17, 2'd0, 3'd0, 32'h0BAD_F00D, 0, 1'b1, 32'h0BAD_F00D, 1'b0);
    issue_alu(5'd18, 32'h0000_0042, 1'b1); settle();

    // mem_rvalid while idle is ignored
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h9999_9999;
    repeat (2) begin
      @(posedge clk); #1;
    end
    bus.mem_rvalid = 1'b0;
    settle();

    // Reset during WAIT_LOAD with mem_rvalid in the same cycle
    bus.in_valid     = 1'b1;
    bus.in_memtoreg  = 1'b1;
    bus.in_regwrite  = 1'b1;
    bus.in_writereg  = 5'd20;
    bus.in_aluresult = 32'h0000_0100;
    bus.in_loadtype  = 3'd0;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.in_memtoreg = 1'b0;
    @(posedge clk); #1;
    reset          = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    @(posedge clk); #1;
    reset          = 1'b0;
    bus.mem_rvalid = 1'b0;
    model_count    = 32'd0;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_wait_regwrite", {31'd0, RegWrite}, 32'd0);
    end
    check_eq("rst_wait_ready", {31'd0, bus.in_ready}, 32'd1);
    settle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
